pipe_stage_elastic: RTL

- Parametrised, elastic successor to the fixed ID/EX-style pipeline register.
- Carries an arbitrary data payload and a control bundle between two pipeline stages using a valid/ready handshake.
- Has an optional 2-entry skid buffer, so in_ready is registered and does not depend on out_ready combinationally.
- Supports a synchronous flush that forces a NOP control bundle, and keeps a saturating count of downstream bubble cycles for performance analysis.

---
 rtl/pipe_stage_elastic.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: carries a data payload and a control bundle between
// two pipeline stages over a valid/ready handshake. With SKID_EN=1 a second
// (skid) entry lets in_ready come straight from a flop, so it never depends
// combinationally on out_ready. Includes a synchronous flush that empties the
// stage, and a saturating counter of downstream bubble cycles.
module pipe_stage_elastic #(
  parameter int                DATA_W   = 96,
  parameter int                CTRL_W   = 24,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                SKID_EN  = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // State value doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: the counter parks at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic                vld_p1;
  logic                in_ready_p1;
  logic [DATA_W-1:0]   head_data_p1;
  logic [CTRL_W-1:0]   head_ctrl_p1;
  logic [DATA_W-1:0]   skid_data_p1;
  logic [CTRL_W-1:0]   skid_ctrl_p1;
  logic [CNT_W-1:0]    bubble_p1;
  logic                accept;
  logic                emit;
  logic                load_head_in;
  logic                load_head_skid;
  logic                load_skid;

  assign vld_p1 = (state_q != ST_EMPTY);

  // Without the skid entry the stage can only take a new entry when the head
  // leaves in the same cycle (or there is no head), so FULL is unreachable.
  assign in_ready = SKID_EN ? in_ready_p1 : (out_ready | ~vld_p1);

  assign accept = in_valid & in_ready;
  assign emit   = vld_p1 & out_ready;

  // Next-state and register-load selection; flush overrides the handshake.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_BUSY;
            load_head_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d        = ST_BUSY;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Control state: entry count, registered in_ready and bubble counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_p1 <= 1'b1;
      bubble_p1   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_p1 <= (state_d != ST_FULL);
      if (out_ready && !vld_p1) begin
        bubble_p1 <= sat_inc(bubble_p1);
      end
    end
  end

  // Head entry: refilled from upstream or promoted from the skid entry;
  // otherwise held so the outputs stay stable under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data_p1 <= '0;
      head_ctrl_p1 <= '0;
    end else if (load_head_in) begin
      head_data_p1 <= in_data;
      head_ctrl_p1 <= in_ctrl;
    end else if (load_head_skid) begin
      head_data_p1 <= skid_data_p1;
      head_ctrl_p1 <= skid_ctrl_p1;
    end
  end

  // Skid entry: captures the arrival that lands while the head is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data_p1 <= '0;
      skid_ctrl_p1 <= '0;
    end else if (load_skid) begin
      skid_data_p1 <= in_data;
      skid_ctrl_p1 <= in_ctrl;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = head_data_p1;
  assign out_ctrl   = vld_p1 ? head_ctrl_p1 : CTRL_NOP;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_p1;

endmodule
